// File: rtl/wave_gen_pkg.sv
// Shared encodings for the AXI-Stream waveform source: modes, FSM states and
// the noise LFSR polynomial.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP     = 2'd0,
    MODE_SQUARE   = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_NOISE    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // Right-shifting Galois step: feedback from bit 0 folds the taps back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/axis_wave_gen_lfsr.sv
// 32-bit Galois LFSR for the noise mode; a zero seed would lock up, so it is
// replaced by 1.
module lfsr32_galois
  import wave_gen_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] seed_nz;

  assign seed_nz = (seed == 32'h0) ? 32'h1 : seed;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= seed_nz;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/axis_wave_gen.sv
// Multi-channel AXI-Stream waveform source (ramp/square/triangle/noise) with
// channel-interleaved, tuser/tlast framed output.
//
// state    | meaning
// ST_IDLE  | no beat held, waiting for enable_i
// ST_RUN   | streaming, frames repeat back to back
// ST_DRAIN | enable_i dropped, finishing the current frame through tlast
module axis_wave_gen
  import wave_gen_pkg::*;
#(
  parameter int          DW        = 16,
  parameter int          CHANNELS  = 2,
  parameter int          PHASE_W   = 24,
  parameter logic [31:0] LFSR_SEED = 32'h1,
  localparam int         TW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               ce,
  input  logic               enable_i,
  input  logic [1:0]         mode_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic [15:0]        frame_len_i,
  output logic [DW-1:0]      tdata_m_o,
  output logic [TW-1:0]      tid_m_o,
  output logic               tuser_m_o,
  output logic               tlast_m_o,
  output logic               tvalid_m_o,
  input  logic               tready_m_i,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam logic [TW-1:0]      CH_LAST = TW'(CHANNELS - 1);
  localparam logic [PHASE_W:0]   PH_FULL = {1'b1, {PHASE_W{1'b0}}};
  localparam logic [PHASE_W-1:0] CH_OFS  = PHASE_W'(PH_FULL / CHANNELS);

  state_e               state, state_nxt;
  logic                 valid_r, tuser_r, tlast_r;
  logic [DW-1:0]        data_r;
  logic [TW-1:0]        ch_cnt, nch;
  logic [15:0]          smp_cnt, nsmp, len_sh, nxt_len, cur_l, nxt_l;
  logic [PHASE_W-1:0]   acc, nacc, inc_sh, phase;
  logic [1:0]           mode_sh, nxt_mode;
  logic [31:0]          lfsr_state;
  logic                 hs, start, relatch, load, nxt_user, nxt_last;
  logic [DW-1:0]        nxt_data;

  function automatic logic [DW-1:0] wave_map(input logic [1:0] m, input logic [DW-1:0] p,
                                             input logic [31:0] noise);
    logic [DW-1:0] t;
    t = p[DW-1] ? ~(p << 1) : (p << 1);
    case (m)
      MODE_RAMP:     wave_map = {~p[DW-1], p[DW-2:0]};
      MODE_SQUARE:   wave_map = p[DW-1] ? {1'b1, {(DW-2){1'b0}}, 1'b1} : {1'b0, {(DW-1){1'b1}}};
      MODE_TRIANGLE: wave_map = {~t[DW-1], t[DW-2:0]};
      default:       wave_map = DW'(noise);
    endcase
  endfunction

  assign hs      = valid_r & ce & tready_m_i;
  assign start   = ce & (state == ST_IDLE) & enable_i;
  // A tlast handshake with enable_i low ends the stream instead of loading.
  assign relatch = start | (hs & tlast_r & enable_i);
  assign load    = start | (hs & (~tlast_r | enable_i));
  assign cur_l   = (len_sh == 16'd0) ? 16'd1 : len_sh;

  always_comb begin
    nxt_mode = relatch ? mode_i : mode_sh;
    nxt_len  = relatch ? frame_len_i : len_sh;
    nch      = ch_cnt;
    nsmp     = smp_cnt;
    nacc     = acc;
    if (start) begin
      nch  = '0;
      nsmp = '0;
      nacc = '0;
    end else if (ch_cnt == CH_LAST) begin
      nch  = '0;
      nacc = acc + inc_sh;
      nsmp = (smp_cnt == cur_l - 16'd1) ? 16'd0 : smp_cnt + 16'd1;
    end else begin
      nch = ch_cnt + TW'(1);
    end
    nxt_l    = (nxt_len == 16'd0) ? 16'd1 : nxt_len;
    nxt_user = (nsmp == 16'd0) && (nch == '0);
    nxt_last = (nsmp == nxt_l - 16'd1) && (nch == CH_LAST);
    phase    = nacc + PHASE_W'(nch) * CH_OFS;
    nxt_data = wave_map(nxt_mode, DW'(phase >> (PHASE_W - DW)), lfsr_state);
  end

  lfsr32_galois u_lfsr (
    .clk    (aclk),
    .resetn (aresetn),
    .advance(load),
    .seed   (LFSR_SEED),
    .state  (lfsr_state)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ce) begin
      case (state)
        ST_IDLE: if (enable_i) state_nxt = ST_RUN;
        default: begin
          if (hs && tlast_r && !enable_i) state_nxt = ST_IDLE;
          else if (enable_i)              state_nxt = ST_RUN;
          else                            state_nxt = ST_DRAIN;
        end
      endcase
    end
  end

  always_comb begin
    busy_o = (state != ST_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      tuser_r <= 1'b0;
      tlast_r <= 1'b0;
      ch_cnt  <= '0;
      smp_cnt <= '0;
      acc     <= '0;
      mode_sh <= '0;
      inc_sh  <= '0;
      len_sh  <= '0;
    end else if (ce) begin
      if (relatch) begin
        mode_sh <= mode_i;
        inc_sh  <= phase_inc_i;
        len_sh  <= frame_len_i;
      end
      if (load) begin
        valid_r <= 1'b1;
        data_r  <= nxt_data;
        tuser_r <= nxt_user;
        tlast_r <= nxt_last;
        ch_cnt  <= nch;
        smp_cnt <= nsmp;
        acc     <= nacc;
      end else if (hs) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign tdata_m_o    = data_r;
  assign tid_m_o      = ch_cnt;
  assign tuser_m_o    = tuser_r;
  assign tlast_m_o    = tlast_r;
  assign tvalid_m_o   = valid_r & ce;
  assign frame_done_o = hs & tlast_r;

endmodule

// File: doc/axis_wave_gen.md
Name: axis_wave_gen

Overview:
Parametrised AXI-Stream waveform source, the synthesizable successor to the single-channel random stimulus source used on DSP subsystem benches. Generates ramp, square, triangle or LFSR-noise samples for CHANNELS phase-offset channels. Output is channel-interleaved and framed with tuser (start of frame) and tlast (end of frame). Feeds tdata_s/tvalid_s/tready_s of dsp_subsystem in benches and on-chip self-test.

Parameters:
DW, 16, sample width (signed two's complement)
CHANNELS, 2, interleaved channels (1..16)
PHASE_W, 24, phase accumulator width (>= DW)
LFSR_SEED, 32'h1, noise seed (0 is replaced by 1)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
ce  in  1  clock enable; 0 freezes all state
enable_i  in  1  run request
mode_i  in  2  0 ramp, 1 square, 2 triangle, 3 noise
phase_inc_i  in  PHASE_W  phase step per sample set
frame_len_i  in  16  samples per channel per frame; 0 treated as 1
tdata_m_o  out  DW  sample
tid_m_o  out  max(1,$clog2(CHANNELS))  channel index of tdata
tuser_m_o  out  1  first beat of frame
tlast_m_o  out  1  last beat of frame
tvalid_m_o  out  1  AXIS valid
tready_m_i  in  1  AXIS ready
busy_o  out  1  state != IDLE
frame_done_o  out  1  one-cycle pulse on tlast handshake

Behaviour:
- Reset (aresetn=0 at aclk edge): all outputs 0, state IDLE, acc=0, LFSR=LFSR_SEED (or 1), counters 0.
- Clock enable: ce=0 means no register update. tvalid_m_o = valid_r & ce, and a handshake counts only when ce=1. This masking of tvalid under ce is intentional and matches dsp_subsystem ce usage.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when enable_i=1. At that transition, latch mode/phase_inc/frame_len into shadow registers, clear acc and counters, and load the first beat (ch0, sample 0). tvalid rises on the cycle after enable_i is sampled (latency 1).
  - RUN -> DRAIN when enable_i=0. Streaming continues in DRAIN.
  - DRAIN -> RUN if enable_i returns to 1 before tlast.
  - DRAIN -> IDLE on the tlast handshake. tvalid is 0 the following cycle.
  - RUN, tlast handshake: shadows re-latch from the inputs. Config changes take effect only at frame boundaries.
- Handshake rules:
  - Beat is held in the output register; tdata/tid/tuser/tlast are stable while tvalid=1 and tready=0.
  - On a handshake, the next beat is loaded the same edge, so throughput is 1 beat/cycle with tready held high. No bubble between frames in RUN.
- Counters:
  - ch_cnt runs 0..CHANNELS-1.
  - smp_cnt runs 0..L-1, where L = max(frame_len,1).
  - tuser = (smp_cnt==0 && ch_cnt==0).
  - tlast = (smp_cnt==L-1 && ch_cnt==CHANNELS-1).
  - ch_cnt wraps on the last channel; smp_cnt then increments, and wraps to 0 after L-1.
  - acc += phase_inc (mod 2^PHASE_W) when ch_cnt wraps.
- Channel phase: ph_k = acc + k*(2^PHASE_W / CHANNELS), mod 2^PHASE_W. p = ph_k[PHASE_W-1 -: DW].
- Sample arithmetic (result DW bits):
  - ramp: p with MSB inverted (0 -> -2^(DW-1)).
  - square: p MSB 0 -> 2^(DW-1)-1, else -(2^(DW-1)-1) (symmetric, e.g. 0x7FFF/0x8001).
  - triangle: t = p[DW-1] ? ~(p<<1) : (p<<1), truncated to DW bits, then MSB inverted.
  - noise: 32-bit Galois LFSR, taps 0x80200003, shifted once per beat load; output = lfsr[DW-1:0]. The LFSR is shared across channels, so successive channels get successive states.
- Phase wrap is natural overflow; no saturation anywhere.
- Reset mid-frame: immediate return to IDLE, tvalid=0 next cycle. No tlast is emitted and no frame_done_o pulse.

Decomposition:
- Package wave_gen_pkg: mode encodings (MODE_RAMP=0 .. MODE_NOISE=3), LFSR taps constant 32'h80200003, state encodings.
- Sub-module lfsr32_galois holds the LFSR. Ports: clk, resetn, advance, seed, state.
- Waveform mapping is a combinational function inside axis_wave_gen.

Test Plan:
- DW=16, CHANNELS=1, mode 0, phase_inc=24'h000100, frame_len=4, tready=1 -> tdata 8000,8001,8002,8003; tuser on beat 0, tlast on beat 3; frame_done_o pulses once.
- CHANNELS=2, mode 1, phase_inc=0 -> ch0 (phase 0) = 7FFF, ch1 (phase 800000) = 8001; tid alternates 0,1; tlast on ch1 of the last sample.
- Random tready backpressure (50%), mode 2, 10 frames -> no beat lost or duplicated; outputs stable while stalled; sample sequence identical to the tready=1 run.
- enable_i dropped mid-frame at sample 2 of frame_len=8 -> remaining beats through tlast delivered, then IDLE, busy_o=0. Re-enable restarts at acc=0 with tuser.
- mode 3, LFSR_SEED=0 -> first state 1; first 4 outputs match the reference Galois model; ce=0 for 5 cycles mid-stream -> tvalid low, sequence resumes unchanged.
- aresetn asserted mid-frame, tready=0 -> next cycle tvalid=0, busy_o=0; after release and enable, the first beat has tuser=1.
